// File: rtl/pipe_hazard_ctrl.sv
// Issue controller for the 4-stage pipeline: decode, RAW stall via 3-slot scoreboard, JMP redirect, HALT drain.
// Zero-cycle combinational controls; scoreboard/counters update at the next edge; stalls freeze the PC and inject bubbles.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 8,
  parameter int RET_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [7:0]       instrcode,
  output logic             regwrite,
  output logic             wbsel,
  output logic             ifid_flush,
  output logic             pc_en,
  output logic             pc_load,
  output logic [5:0]       pc_target,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [RET_W-1:0] retire_cnt
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  state_t           state_q, state_d;
  logic             sid_vld_q, sid_vld_d, sex_vld_q, sex_vld_d, swb_vld_q, swb_vld_d;
  logic [2:0]       sid_dst_q, sid_dst_d, sex_dst_q, sex_dst_d, swb_dst_q, swb_dst_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [RET_W-1:0] retire_cnt_q, retire_cnt_d;
  logic             halted_q, halted_d;

  logic [1:0] opcode;
  logic [2:0] rd, rs;
  logic       hazard;

  assign opcode    = instrcode[7:6];
  assign rd        = instrcode[5:3];
  assign rs        = instrcode[2:0];
  assign pc_target = instrcode[5:0];

  // s_wb is deliberately excluded: it commits at the same edge the consumer enters ID.
  assign hazard = (opcode == 2'b00) &&
                  ((sid_vld_q && (sid_dst_q == rd || sid_dst_q == rs)) ||
                   (sex_vld_q && (sex_dst_q == rd || sex_dst_q == rs)));

  assign stall_cnt  = stall_cnt_q;
  assign retire_cnt = retire_cnt_q;
  assign halted     = halted_q;

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    pc_en       = 1'b0;
    pc_load     = 1'b0;
    ifid_flush  = 1'b1;
    regwrite    = 1'b0;
    wbsel       = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_RUN: begin
          if (instr_valid) begin
            if (hazard) begin
              if (stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end else if (opcode == 2'b11) begin
              pc_load = 1'b1;
            end else if (opcode == 2'b10) begin
              state_d = ST_DRAIN;
            end else begin
              pc_en      = 1'b1;
              ifid_flush = 1'b0;
              regwrite   = 1'b1;
              wbsel      = (opcode == 2'b01);
            end
          end
        end
        // Post-shift occupancy is just the current s_id and s_ex moving down.
        ST_DRAIN: if (!sid_vld_q && !sex_vld_q) state_d = ST_HALTED;
        default: ;
      endcase
    end
    sid_vld_d    = regwrite;
    sid_dst_d    = rd;
    sex_vld_d    = sid_vld_q;
    sex_dst_d    = sid_dst_q;
    swb_vld_d    = sex_vld_q;
    swb_dst_d    = sex_dst_q;
    retire_cnt_d = retire_cnt_q + RET_W'(swb_vld_q);
    halted_d     = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      sid_vld_q    <= 1'b0;
      sex_vld_q    <= 1'b0;
      swb_vld_q    <= 1'b0;
      sid_dst_q    <= 3'd0;
      sex_dst_q    <= 3'd0;
      swb_dst_q    <= 3'd0;
      stall_cnt_q  <= '0;
      retire_cnt_q <= '0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sid_vld_q    <= sid_vld_d;
      sex_vld_q    <= sex_vld_d;
      swb_vld_q    <= swb_vld_d;
      sid_dst_q    <= sid_dst_d;
      sex_dst_q    <= sex_dst_d;
      swb_dst_q    <= swb_dst_d;
      stall_cnt_q  <= stall_cnt_d;
      retire_cnt_q <= retire_cnt_d;
      halted_q     <= halted_d;
    end
  end

endmodule
